// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receive/transmit state encoding.
package uart_pkg;

  localparam int OVERSAMPLE_RATE = 16;
  localparam int BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

endpackage

// File: rtl/receiver_if.sv
// Serial receive bus: line and oversample strobe in, received byte and status pulses out.
interface receiver_if #(
  parameter int BITS = uart_pkg::BITS
);

  logic            i_RX;
  logic            i_TICK;
  logic [BITS-1:0] o_RX_DATA;
  logic            o_RX_DV;
  logic            o_RX_ERR;

  modport master (
    output i_RX, i_TICK,
    input  o_RX_DATA, o_RX_DV, o_RX_ERR
  );

  modport slave (
    input  i_RX, i_TICK,
    output o_RX_DATA, o_RX_DV, o_RX_ERR
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module sync_2ff (
  input  logic P_CLK,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge P_CLK or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/receiver.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data capture, stop-bit check.
module receiver #(
  parameter int OVERSAMPLE_RATE = uart_pkg::OVERSAMPLE_RATE,
  parameter int BITS            = uart_pkg::BITS
) (
  input  logic       P_CLK,
  input  logic       reset,
  receiver_if.slave  bus
);

  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE_RATE);
  localparam int BW = $clog2(BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);

  state_t          r_state;
  logic [TW-1:0]   r_tick_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [BITS-1:0] r_shift;
  logic [BITS-1:0] r_rx_data;
  logic            r_rx_dv;
  logic            r_rx_err;
  logic            r_rx_prev;
  logic [1:0]      r_warm;

  state_t          w_state_next;
  logic [TW-1:0]   w_tick_cnt_next;
  logic [BW-1:0]   w_bit_cnt_next;
  logic [BITS-1:0] w_shift_next;
  logic [BITS-1:0] w_rx_data_next;
  logic            w_rx_dv_next;
  logic            w_rx_err_next;
  logic            w_rx_s;
  logic            w_fall;
  logic            w_sample;

  sync_2ff u_sync (
    .P_CLK (P_CLK),
    .reset (reset),
    .i_d   (bus.i_RX),
    .o_q   (w_rx_s)
  );

  // A start edge needs a genuine high level before it. The edge-detect history stays low
  // until the reset value has flushed out of the synchronizer, so a line held low through
  // reset, or a break after a framing error, never looks like a falling edge.
  assign w_fall = r_rx_prev & ~w_rx_s;

  // Mid-bit sampling instants: half a bit into START, a full bit into each DATA/STOP bit.
  assign w_sample = bus.i_TICK &&
                    (r_state == START ? (r_tick_cnt == TICK_MID) : (r_tick_cnt == TICK_LAST));

  // Next-state decision.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_next = START;
      START:   if (w_sample) w_state_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_sample && r_bit_cnt == BIT_LAST) w_state_next = STOP;
      STOP:    if (w_sample) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Counter, shift-register and output-pulse updates; counters move only on i_TICK.
  always_comb begin
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_rx_data_next  = r_rx_data;
    w_rx_dv_next    = 1'b0;
    w_rx_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) w_tick_cnt_next = '0;
      end
      START: begin
        if (w_sample) begin
          w_tick_cnt_next = '0;
          w_bit_cnt_next  = '0;
        end else if (bus.i_TICK) begin
          w_tick_cnt_next = r_tick_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_sample) begin
          w_tick_cnt_next          = '0;
          w_shift_next[r_bit_cnt]  = w_rx_s;
          if (r_bit_cnt != BIT_LAST) w_bit_cnt_next = r_bit_cnt + 1'b1;
        end else if (bus.i_TICK) begin
          w_tick_cnt_next = r_tick_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_sample) begin
          w_tick_cnt_next = '0;
          if (w_rx_s) begin
            w_rx_data_next = r_shift;
            w_rx_dv_next   = 1'b1;
          end else begin
            w_rx_err_next  = 1'b1;
          end
        end else if (bus.i_TICK) begin
          w_tick_cnt_next = r_tick_cnt + 1'b1;
        end
      end
      default: w_tick_cnt_next = '0;
    endcase
  end

  // All receiver state, counters and registered outputs.
  always_ff @(posedge P_CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_dv    <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_prev  <= 1'b0;
      r_warm     <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_rx_data  <= w_rx_data_next;
      r_rx_dv    <= w_rx_dv_next;
      r_rx_err   <= w_rx_err_next;
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      r_rx_prev  <= (r_warm == 2'd2) ? w_rx_s : 1'b0;
    end
  end

  assign bus.o_RX_DATA = r_rx_data;
  assign bus.o_RX_DV   = r_rx_dv;
  assign bus.o_RX_ERR  = r_rx_err;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for the UART receiver: directed scenarios plus randomized frames
// compared against a frame-level expectation model.
module tb_receiver;

  import uart_pkg::*;

  localparam int OSR = OVERSAMPLE_RATE;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         tick;
  } ev_t;

  logic P_CLK = 1'b0;
  logic reset = 1'b0;

  receiver_if bus ();

  receiver #(
    .OVERSAMPLE_RATE (OVERSAMPLE_RATE),
    .BITS            (BITS)
  ) dut (
    .P_CLK (P_CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 P_CLK = ~P_CLK;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         both_high = 0;
  int         tick_seen = 0;
  int         tick_div  = 2;
  logic [7:0] last_data = 8'h00;

  // Count oversample strobes as the design sees them.
  always @(posedge P_CLK) begin
    if (bus.i_TICK) tick_seen <= tick_seen + 1;
  end

  // Record every status pulse with the data present and the tick it occurred on.
  always @(negedge P_CLK) begin
    if (bus.o_RX_DV && bus.o_RX_ERR) both_high++;
    if (bus.o_RX_DV || bus.o_RX_ERR)
      obs_q.push_back('{err: bus.o_RX_ERR, data: bus.o_RX_DATA, tick: tick_seen});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One oversample period: a single-cycle strobe followed by idle cycles.
  task automatic tick_period();
    for (int c = 0; c < tick_div; c++) begin
      @(negedge P_CLK);
      bus.i_TICK = (c == 0);
    end
  endtask

  task automatic hold(input bit lvl, input int n);
    bus.i_RX = lvl;
    for (int k = 0; k < n; k++) tick_period();
  endtask

  // Drive one frame; edges may be displaced by up to +/-jit ticks. The model predicts the
  // outcome purely from the frame contents.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int jit);
    int edge_pos[11];
    bit lvl[10];
    lvl[0] = 1'b0;
    for (int k = 1; k <= 8; k++) lvl[k] = d[k-1];
    lvl[9] = stop_ok;
    edge_pos[0]  = 0;
    edge_pos[10] = 10 * OSR;
    for (int k = 1; k < 10; k++)
      edge_pos[k] = OSR * k + ((jit > 0) ? (int'($urandom_range(0, 2 * jit)) - jit) : 0);
    for (int k = 0; k < 10; k++) hold(lvl[k], edge_pos[k+1] - edge_pos[k]);
    if (stop_ok) begin
      exp_q.push_back('{err: 1'b0, data: d, tick: 0});
      last_data = d;
    end else begin
      exp_q.push_back('{err: 1'b1, data: last_data, tick: 0});
    end
  endtask

  task automatic check_events(input string tag);
    #1;
    check({tag, "/count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      check({tag, "/kind"}, obs_q[k].err, exp_q[k].err);
      check({tag, "/data"}, obs_q[k].data, exp_q[k].data);
    end
    $display("[TB] %s: %0d pulses observed, %0d expected", tag, obs_q.size(), exp_q.size());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rd;
    int         r;
    bus.i_RX   = 1'b0;
    bus.i_TICK = 1'b0;

    // Reset state, with the line low throughout reset.
    repeat (3) @(negedge P_CLK);
    check("rst/data", bus.o_RX_DATA, 8'h00);
    check("rst/dv",   bus.o_RX_DV,   1'b0);
    check("rst/err",  bus.o_RX_ERR,  1'b0);
    reset = 1'b1;

    // A line low out of reset must not start a frame.
    hold(1'b0, 40);
    hold(1'b1, 20);
    check_events("low_from_reset");

    // Single frame 0xA5.
    send_frame(8'hA5, 1'b1, 0);
    hold(1'b1, 20);
    check_events("frame_A5");
    check("A5/data_held", bus.o_RX_DATA, last_data);

    // Back-to-back 0x00 then 0xFF with a one-bit stop.
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    hold(1'b1, 20);
    #1;
    if (obs_q.size() >= 2) check("b2b/spacing", obs_q[1].tick - obs_q[0].tick, 2 * 0 + 10 * OSR);
    else                   check("b2b/pulses", obs_q.size(), 2);
    check_events("b2b_00_FF");

    // Short low glitch on the idle line.
    hold(1'b0, 4);
    hold(1'b1, 20);
    check_events("glitch");
    check("glitch/data_held", bus.o_RX_DATA, last_data);

    // Framing error followed by a break, then recovery.
    send_frame(8'h3C, 1'b0, 0);
    hold(1'b0, 40);
    check_events("ferr_3C");
    check("ferr/data_held", bus.o_RX_DATA, last_data);
    hold(1'b1, 4);
    send_frame(8'h3C, 1'b1, 0);
    hold(1'b1, 20);
    check_events("after_ferr");

    // Reset in the middle of data bit 4 of 0x5A, then a clean 0x5A.
    hold(1'b0, OSR);
    for (int k = 0; k < 4; k++) hold(((8'h5A >> k) & 8'h01) != 0, OSR);
    hold(1'b1, OSR / 2);
    @(negedge P_CLK);
    reset = 1'b0;
    #1;
    check("rst_async/data", bus.o_RX_DATA, 8'h00);
    check("rst_async/dv",   bus.o_RX_DV,   1'b0);
    @(negedge P_CLK);
    reset = 1'b1;
    last_data = 8'h00;
    hold(1'b1, 24);
    check_events("aborted_5A");
    send_frame(8'h5A, 1'b1, 0);
    hold(1'b1, 20);
    check_events("clean_5A");

    // Slower strobe with jittered edges.
    tick_div = 3;
    send_frame(8'h81, 1'b1, 3);
    hold(1'b1, 20);
    check_events("jitter_81");
    for (int k = 0; k < 4; k++) begin
      rd = 8'($urandom);
      send_frame(rd, 1'b1, 3);
      hold(1'b1, $urandom_range(0, 8));
    end
    hold(1'b1, 20);
    check_events("jitter_random");

    // Randomized mix of frames, bad stops and glitches.
    tick_div = 2;
    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        hold(1'b0, $urandom_range(1, 5));
        hold(1'b1, 12);
      end else begin
        rd = 8'($urandom);
        send_frame(rd, r != 1, 0);
        if (r == 1) begin
          hold(1'b0, $urandom_range(0, 20));
          hold(1'b1, $urandom_range(1, 10));
        end else begin
          hold(1'b1, $urandom_range(0, 10));
        end
      end
    end
    hold(1'b1, 20);
    check_events("random");
    check("random/data_held", bus.o_RX_DATA, last_data);

    check("dv_err_exclusive", both_high, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
